sys_rst_sequencer: RTL and testbench

SYS_RST_SEQUENCER -- requirements
Module: sys_rst_sequencer

---
 rtl/sys_rst_sequencer.sv | 136 +++++++++++++
 tb/tb_sys_rst_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_rst_sequencer.sv
// rtl/sys_rst_sequencer.sv - staged power-on / lock / system / peripheral reset release sequencer
// Also restarts the sequence on PLL lock loss or a debounced reset-switch press.
module sys_rst_sequencer #(
    parameter int pPorCnt      = 1000,
    parameter int pLockStable  = 16,
    parameter int pStageGap    = 8,
    parameter int pDebounce    = 50000,
    parameter int pRstSwIdx    = 0,
    parameter int pSwActiveLow = 1
) (
    input  logic       iSysClk,
    input  logic       iSysRst,
    input  logic       iPllLocked,
    input  logic [3:0] iUserPushSw,
    output logic       oSysRst,
    output logic       oPeriRst,
    output logic       oRstDone,
    output logic [2:0] oFsmState,
    output logic [1:0] oRstCause
);

    localparam int MAX_AB = (pPorCnt > pLockStable) ? pPorCnt : pLockStable;
    localparam int MAX_CD = (pStageGap > pDebounce) ? pStageGap : pDebounce;
    localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] POR_LAST  = CW'(pPorCnt - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(pLockStable - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(pStageGap - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(pDebounce - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic          SW_ACT_LOW = (pSwActiveLow != 0);

    typedef enum logic [2:0] {
        ST_POR  = 3'd0,
        ST_LOCK = 3'd1,
        ST_SYS  = 3'd2,
        ST_PERI = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          arm_q, arm_d;
    logic [1:0]    cause_q, cause_d;
    logic          sw_pressed;
    logic          deb_hit;
    logic          unused_sw;

    assign sw_pressed = iUserPushSw[pRstSwIdx] ^ SW_ACT_LOW;
    // Only the selected switch matters; the rest are folded away on purpose.
    assign unused_sw  = ^iUserPushSw;
    assign deb_hit    = (state_q == ST_RUN) && sw_pressed && arm_q && (dcnt_q == DEB_LAST);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        arm_d   = arm_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        dcnt_d  = '0;

        if (!sw_pressed) begin
            arm_d = 1'b1;
        end

        case (state_q)
            ST_POR: begin
                if (cnt_q == POR_LAST) state_d = ST_LOCK;
            end
            ST_LOCK: begin
                if (!iPllLocked)             cnt_d   = '0;
                else if (cnt_q == LOCK_LAST) state_d = ST_SYS;
            end
            ST_SYS: begin
                if (!iPllLocked) begin
                    state_d = ST_LOCK;
                    cause_d = 2'd1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_PERI;
                end
            end
            ST_PERI: begin
                if (!iPllLocked) begin
                    state_d = ST_LOCK;
                    cause_d = 2'd1;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Lock loss wins over a simultaneous switch expiry.
                if (!iPllLocked) begin
                    state_d = ST_LOCK;
                    cause_d = 2'd1;
                end else if (deb_hit) begin
                    state_d = ST_POR;
                    cause_d = 2'd2;
                    arm_d   = 1'b0;
                end
            end
            default: state_d = ST_POR;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        if ((state_q == ST_RUN) && (state_d == ST_RUN) && sw_pressed && arm_q) begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    always_ff @(posedge iSysClk) begin
        if (iSysRst) begin
            state_q <= ST_POR;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            arm_q   <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            arm_q   <= arm_d;
            cause_q <= cause_d;
        end
    end

    assign oSysRst   = (state_q == ST_POR) || (state_q == ST_LOCK);
    assign oPeriRst  = (state_q == ST_POR) || (state_q == ST_LOCK) || (state_q == ST_SYS);
    assign oRstDone  = (state_q == ST_RUN);
    assign oFsmState = state_q;
    assign oRstCause = cause_q;

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// tb/tb_sys_rst_sequencer.sv - directed and randomized checks of sys_rst_sequencer against a duration-based model
module tb_sys_rst_sequencer;

    localparam int POR = 10;
    localparam int LCK = 4;
    localparam int GAP = 3;
    localparam int DEB = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       lk;
    logic [3:0] sw;
    logic       sys_rst, peri_rst, rst_done;
    logic [2:0] fsm_state;
    logic [1:0] rst_cause;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;

    // Model: phase number, cycles spent in it, lock streak, qualifying press length
    int m_st, m_age, m_streak, m_press, m_armed, m_cause;

    always #5 clk = ~clk;

    sys_rst_sequencer #(
        .pPorCnt     (POR),
        .pLockStable (LCK),
        .pStageGap   (GAP),
        .pDebounce   (DEB),
        .pRstSwIdx   (0),
        .pSwActiveLow(1)
    ) dut (
        .iSysClk    (clk),
        .iSysRst    (rst),
        .iPllLocked (lk),
        .iUserPushSw(sw),
        .oSysRst    (sys_rst),
        .oPeriRst   (peri_rst),
        .oRstDone   (rst_done),
        .oFsmState  (fsm_state),
        .oRstCause  (rst_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic l, input logic [3:0] s);
        int  nxt;
        int  streak;
        int  presses;
        bit  pressed;
        pressed = (s[0] == 1'b0);
        if (r) begin
            m_st = 0; m_age = 0; m_streak = 0; m_press = 0; m_armed = 0; m_cause = 0;
            return;
        end
        nxt     = m_st;
        streak  = 0;
        presses = 0;
        case (m_st)
            0: if (m_age + 1 >= POR) nxt = 1;
            1: begin
                streak = l ? m_streak + 1 : 0;
                if (streak >= LCK) nxt = 2;
            end
            2, 3: begin
                if (!l) begin
                    nxt = 1; m_cause = 1;
                end else if (m_age + 1 >= GAP) begin
                    nxt = m_st + 1;
                end
            end
            4: begin
                presses = (pressed && m_armed != 0) ? m_press + 1 : 0;
                if (!l) begin
                    nxt = 1; m_cause = 1;
                end else if (presses >= DEB) begin
                    nxt = 0; m_cause = 2; m_armed = 0;
                end
            end
            default: nxt = 0;
        endcase
        if (!pressed) m_armed = 1;
        m_streak = (nxt == 1 && m_st == 1) ? streak : 0;
        m_press  = (nxt == 4 && m_st == 4) ? presses : 0;
        m_age    = (nxt == m_st) ? m_age + 1 : 0;
        m_st     = nxt;
    endtask

    task automatic check_all();
        chk("state",    fsm_state, m_st);
        chk("sys_rst",  sys_rst,   (m_st <= 1));
        chk("peri_rst", peri_rst,  (m_st <= 2));
        chk("rst_done", rst_done,  (m_st == 4));
        chk("cause",    rst_cause, m_cause);
    endtask

    task automatic tick(input logic r, input logic l, input logic [3:0] s);
        rst = r; lk = l; sw = s;
        @(posedge clk);
        #1;
        model_step(r, l, s);
        if (r) cyc = 0;
        else   cyc++;
        check_all();
    endtask

    task automatic run_to_run();
        for (int i = 0; i < 100 && m_st != 4; i++) tick(1'b0, 1'b1, 4'hF);
        chk("reach_run", fsm_state, 4);
    endtask

    initial begin
        logic       s0;
        logic [2:0] hi;
        rst = 1'b1; lk = 1'b0; sw = 4'hF;
        m_st = 0; m_age = 0; m_streak = 0; m_press = 0; m_armed = 0; m_cause = 0;

        tick(1'b1, 1'b0, 4'hF);
        tick(1'b1, 1'b1, 4'hF);
        chk("rst_state", fsm_state, 0);
        chk("rst_done0", rst_done, 0);

        // Clean sequence with lock held high
        for (int i = 0; i < 25; i++) begin
            tick(1'b0, 1'b1, 4'hF);
            if (cyc == 9)  chk("a_c9_por",   fsm_state, 0);
            if (cyc == 10) chk("a_c10_lock", fsm_state, 1);
            if (cyc == 13) chk("a_c13_lock", fsm_state, 1);
            if (cyc == 14) chk("a_c14_sys",  fsm_state, 2);
            if (cyc == 14) chk("a_c14_srst", sys_rst, 0);
            if (cyc == 16) chk("a_c16_prst", peri_rst, 1);
            if (cyc == 17) chk("a_c17_peri", fsm_state, 3);
            if (cyc == 17) chk("a_c17_prst", peri_rst, 0);
            if (cyc == 20) chk("a_c20_done", rst_done, 1);
        end

        // Lock glitch at cycle 12 restarts the lock streak
        tick(1'b1, 1'b1, 4'hF);
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, (cyc != 12), 4'hF);
            if (cyc == 14) chk("b_c14_lock", fsm_state, 1);
            if (cyc == 16) chk("b_c16_lock", fsm_state, 1);
            if (cyc == 17) chk("b_c17_sys",  fsm_state, 2);
        end

        // Lock loss in RUN
        run_to_run();
        tick(1'b0, 1'b0, 4'hF);
        chk("c_lock",  fsm_state, 1);
        chk("c_cause", rst_cause, 1);
        chk("c_srst",  sys_rst, 1);
        repeat (9) tick(1'b0, 1'b1, 4'hF);
        chk("c_not_yet", rst_done, 0);
        tick(1'b0, 1'b1, 4'hF);
        chk("c_rerun", fsm_state, 4);

        // Other switches ignored; short press ignored; full press resets
        repeat (8) tick(1'b0, 1'b1, 4'h1);
        chk("d_other_sw", fsm_state, 4);
        repeat (4) tick(1'b0, 1'b1, 4'h0);
        tick(1'b0, 1'b1, 4'hF);
        chk("d_short", fsm_state, 4);
        repeat (5) tick(1'b0, 1'b1, 4'hE);
        chk("d_press_st",    fsm_state, 0);
        chk("d_press_cause", rst_cause, 2);

        // Switch held through re-sequencing: no second reset
        repeat (40) tick(1'b0, 1'b1, 4'hE);
        chk("e_held_run", fsm_state, 4);
        tick(1'b0, 1'b1, 4'hF);
        repeat (5) tick(1'b0, 1'b1, 4'hE);
        chk("e_repress", fsm_state, 0);

        // Reset pulse during PERI
        run_to_run();
        tick(1'b0, 1'b0, 4'hF);
        for (int i = 0; i < 50 && m_st != 3; i++) tick(1'b0, 1'b1, 4'hF);
        chk("f_in_peri", fsm_state, 3);
        tick(1'b1, 1'b1, 4'hF);
        chk("f_rst_st",    fsm_state, 0);
        chk("f_rst_cause", rst_cause, 0);

        // Lock loss and switch expiry in the same cycle
        run_to_run();
        repeat (4) tick(1'b0, 1'b1, 4'hE);
        tick(1'b0, 1'b0, 4'hE);
        chk("g_prio_st",    fsm_state, 1);
        chk("g_prio_cause", rst_cause, 1);

        // Randomized traffic
        s0 = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) s0 = ~s0;
            hi = 3'($urandom_range(0, 7));
            tick(($urandom_range(0, 399) == 0), ($urandom_range(0, 39) != 0), {hi, s0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
